// File: rtl/coinc_pkg.sv
// Shared types and default widths for the coincidence-counting core.
package coinc_pkg;

    typedef enum logic [1:0] {
        ACQ_IDLE,
        ACQ_RUN,
        ACQ_DONE
    } acq_state_t;

    typedef enum logic {
        W_IDLE,
        W_OPEN
    } win_state_t;

    localparam int unsigned DefNCh  = 4;
    localparam int unsigned DefWinW = 16;
    localparam int unsigned DefCntW = 32;

endpackage

// File: rtl/coinc_edge_sync.sv
// N-wide two-flop synchroniser followed by a rising-edge detector.
module coinc_edge_sync #(
    parameter int unsigned NCh = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [NCh-1:0] async_i,
    output logic [NCh-1:0] edge_o
);

    logic [NCh-1:0] sync1_q;
    logic [NCh-1:0] sync2_q;
    logic [NCh-1:0] prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Edge is presented during the cycle before the third flop captures it.
    assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/coinc_core.sv
// Coincidence counter: gated acquisition FSM, coincidence-window FSM, saturating counters.
module coinc_core
    import coinc_pkg::*;
#(
    parameter int unsigned N_CH  = DefNCh,
    parameter int unsigned WIN_W = DefWinW,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [N_CH-1:0]       ch_in,
    input  logic                  cfg_start,
    input  logic                  cfg_clear,
    input  logic [WIN_W-1:0]      cfg_window,
    input  logic [N_CH-1:0]       cfg_mask,
    input  logic [CNT_W-1:0]      cfg_gate,
    output logic [CNT_W-1:0]      coinc_count,
    output logic [N_CH*CNT_W-1:0] singles_count,
    output logic                  coinc_pulse,
    output logic                  busy,
    output logic                  done
);

    logic [N_CH-1:0] edges;

    coinc_edge_sync #(
        .NCh (N_CH)
    ) u_edge_sync (
        .clk_i   (ACLK),
        .rst_ni  (ARESETN),
        .async_i (ch_in),
        .edge_o  (edges)
    );

    acq_state_t                 acq_q;
    win_state_t                 win_q;
    logic [N_CH-1:0]            hits_q;
    logic [WIN_W-1:0]           wtimer_q;
    logic [CNT_W-1:0]           gate_q;
    logic [CNT_W-1:0]           coinc_q;
    logic [N_CH-1:0][CNT_W-1:0] singles_q;
    logic                       pulse_q;
    logic                       busy_q;
    logic                       done_q;

    logic [N_CH-1:0] e_masked;
    logic            coinc_det;
    logic            win_open;
    logic            win_close;

    always_comb begin
        e_masked  = edges & cfg_mask;
        coinc_det = 1'b0;
        win_open  = 1'b0;
        win_close = 1'b0;
        if (acq_q == ACQ_RUN) begin
            unique case (win_q)
                W_IDLE: begin
                    // An empty mask must never satisfy e == mask.
                    if ((cfg_mask != '0) && (e_masked == cfg_mask)) begin
                        coinc_det = 1'b1;
                    end else if (e_masked != '0) begin
                        win_open = 1'b1;
                    end
                end
                W_OPEN: begin
                    if ((hits_q | e_masked) == cfg_mask) begin
                        coinc_det = 1'b1;
                    end else if (wtimer_q == '0) begin
                        win_close = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            acq_q     <= ACQ_IDLE;
            win_q     <= W_IDLE;
            hits_q    <= '0;
            wtimer_q  <= '0;
            gate_q    <= '0;
            coinc_q   <= '0;
            singles_q <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (cfg_clear) begin
            acq_q     <= ACQ_IDLE;
            win_q     <= W_IDLE;
            hits_q    <= '0;
            wtimer_q  <= '0;
            gate_q    <= '0;
            coinc_q   <= '0;
            singles_q <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (acq_q)
                ACQ_IDLE, ACQ_DONE: begin
                    pulse_q <= 1'b0;
                    win_q   <= W_IDLE;
                    hits_q  <= '0;
                    if (cfg_start) begin
                        acq_q     <= ACQ_RUN;
                        gate_q    <= cfg_gate;
                        coinc_q   <= '0;
                        singles_q <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                ACQ_RUN: begin
                    pulse_q <= coinc_det;
                    if (coinc_det && (coinc_q != '1)) begin
                        coinc_q <= coinc_q + CNT_W'(1);
                    end
                    for (int i = 0; i < int'(N_CH); i++) begin
                        if (edges[i] && (singles_q[i] != '1)) begin
                            singles_q[i] <= singles_q[i] + CNT_W'(1);
                        end
                    end

                    case (win_q)
                        W_IDLE: begin
                            if (win_open) begin
                                win_q    <= W_OPEN;
                                hits_q   <= e_masked;
                                wtimer_q <= cfg_window;
                            end
                        end
                        W_OPEN: begin
                            // Edges in the terminating cycle are dropped, not used to re-arm.
                            if (coinc_det || win_close) begin
                                win_q  <= W_IDLE;
                                hits_q <= '0;
                            end else begin
                                hits_q   <= hits_q | e_masked;
                                wtimer_q <= wtimer_q - WIN_W'(1);
                            end
                        end
                        default: win_q <= W_IDLE;
                    endcase

                    // A zero gate never reaches 1, so the run continues until cleared.
                    if (gate_q == CNT_W'(1)) begin
                        acq_q  <= ACQ_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        win_q  <= W_IDLE;
                        hits_q <= '0;
                    end else if (gate_q != '0) begin
                        gate_q <= gate_q - CNT_W'(1);
                    end
                end
                default: acq_q <= ACQ_IDLE;
            endcase
        end
    end

    assign coinc_count   = coinc_q;
    assign singles_count = singles_q;
    assign coinc_pulse   = pulse_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_coinc_core.sv
// Directed bench for coinc_core with a scoreboard of expected coincidence strobes.
module tb_coinc_core;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [3:0]  ch_in = '0;
    logic        cfg_start = 1'b0;
    logic        cfg_clear = 1'b0;
    logic [15:0] cfg_window = '0;
    logic [3:0]  cfg_mask = '0;
    logic [31:0] cfg_gate = '0;

    logic [31:0]  coinc_count;
    logic [127:0] singles_count;
    logic         coinc_pulse, busy, done;

    logic [3:0]  coinc_count4;
    logic [15:0] singles_count4;
    logic        coinc_pulse4, busy4, done4;

    coinc_core #(.N_CH(4), .WIN_W(16), .CNT_W(32)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .ch_in         (ch_in),
        .cfg_start     (cfg_start),
        .cfg_clear     (cfg_clear),
        .cfg_window    (cfg_window),
        .cfg_mask      (cfg_mask),
        .cfg_gate      (cfg_gate),
        .coinc_count   (coinc_count),
        .singles_count (singles_count),
        .coinc_pulse   (coinc_pulse),
        .busy          (busy),
        .done          (done)
    );

    coinc_core #(.N_CH(4), .WIN_W(16), .CNT_W(4)) dut4 (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .ch_in         (ch_in),
        .cfg_start     (cfg_start),
        .cfg_clear     (cfg_clear),
        .cfg_window    (cfg_window),
        .cfg_mask      (cfg_mask),
        .cfg_gate      (cfg_gate[3:0]),
        .coinc_count   (coinc_count4),
        .singles_count (singles_count4),
        .coinc_pulse   (coinc_pulse4),
        .busy          (busy4),
        .done          (done4)
    );

    always #5 ACLK = ~ACLK;

    int          n_tests = 0;
    int          n_fail = 0;
    int          exp_coinc = 0;
    logic [31:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic pulse(input logic [3:0] bits);
        ch_in = ch_in | bits;
        tick(2);
        ch_in = ch_in & ~bits;
        tick(2);
    endtask

    task automatic expect_coinc();
        exp_coinc++;
        sb_q.push_back(32'(exp_coinc));
    endtask

    task automatic do_start();
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        exp_coinc = 0;
    endtask

    task automatic do_clear();
        cfg_clear = 1'b1;
        tick(1);
        cfg_clear = 1'b0;
        exp_coinc = 0;
    endtask

    // Every strobe must match the next queued expectation of the running count.
    always @(negedge ACLK) begin
        if (ARESETN && coinc_pulse) begin
            chk("pulse_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) chk("pulse_count", coinc_count, sb_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        #3;
        chk("rst_coinc", coinc_count, 32'd0);
        chk("rst_singles0", singles_count[31:0], 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pulse", 32'(coinc_pulse), 32'd0);
        tick(2);
        ARESETN = 1'b1;
        tick(2);

        // 1: ch1 five cycles after ch0 inside a 10-cycle window
        cfg_mask = 4'b0011; cfg_window = 16'd10; cfg_gate = 32'd1000;
        do_start();
        chk("t1_busy", 32'(busy), 32'd1);
        expect_coinc();
        ch_in = 4'b0001; tick(2); ch_in = '0; tick(3);
        ch_in = 4'b0010; tick(2); ch_in = '0; tick(8);
        chk("t1_coinc", coinc_count, 32'd1);
        chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);

        // 2: 12 cycles apart misses, 11 apart hits, window 0 with simultaneous hits
        do_clear(); do_start();
        ch_in = 4'b0001; tick(2); ch_in = '0; tick(10);
        ch_in = 4'b0010; tick(2); ch_in = '0; tick(8);
        chk("t2_late_coinc", coinc_count, 32'd0);
        chk("t2_singles0", singles_count[31:0], 32'd1);
        chk("t2_singles1", singles_count[63:32], 32'd1);
        do_clear(); do_start();
        expect_coinc();
        ch_in = 4'b0001; tick(2); ch_in = '0; tick(9);
        ch_in = 4'b0010; tick(2); ch_in = '0; tick(8);
        chk("t2_edge_coinc", coinc_count, 32'd1);
        do_clear(); cfg_window = 16'd0; do_start();
        expect_coinc();
        ch_in = 4'b0011; tick(2); ch_in = '0; tick(8);
        chk("t2_win0_coinc", coinc_count, 32'd1);
        chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // 3: gate of 50 cycles, then restart zeroes held counts
        do_clear(); cfg_window = 16'd10; cfg_gate = 32'd50;
        do_start();
        k = 0;
        while (busy && k < 200) begin k++; tick(1); end
        chk("t3_busy_cycles", 32'(k), 32'd50);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_busy_low", 32'(busy), 32'd0);
        do_start();
        chk("t3_restart_done", 32'(done), 32'd0);
        expect_coinc();
        ch_in = 4'b0011; tick(2); ch_in = '0;
        k = 0;
        while (!done && k < 200) begin k++; tick(1); end
        chk("t3_gate_in_time", 32'(k < 200), 32'd1);
        chk("t3_held_coinc", coinc_count, 32'd1);
        do_start();
        chk("t3_zeroed_coinc", coinc_count, 32'd0);
        chk("t3_zeroed_done", 32'(done), 32'd0);
        chk("t3_rerun_busy", 32'(busy), 32'd1);

        // 4: single-channel mask counts every pulse; empty mask never counts
        do_clear(); cfg_mask = 4'b0001; cfg_gate = 32'd0;
        do_start();
        for (int i = 0; i < 20; i++) begin expect_coinc(); pulse(4'b0001); end
        tick(6);
        chk("t4_coinc20", coinc_count, 32'd20);
        chk("t4_singles0", singles_count[31:0], 32'd20);
        chk("t4_freerun_busy", 32'(busy), 32'd1);
        chk("t4_sb_empty", 32'(sb_q.size()), 32'd0);
        do_clear(); cfg_mask = 4'b0000; do_start();
        for (int i = 0; i < 5; i++) pulse(4'b0001);
        tick(6);
        chk("t4_mask0_coinc", coinc_count, 32'd0);
        chk("t4_mask0_singles", singles_count[31:0], 32'd5);

        // 5: clear beats start; async reset in the middle of a window
        do_clear(); cfg_mask = 4'b0001; do_start();
        for (int i = 0; i < 3; i++) begin expect_coinc(); pulse(4'b0001); end
        tick(6);
        chk("t5_pre_coinc", coinc_count, 32'd3);
        cfg_clear = 1'b1; cfg_start = 1'b1; tick(1); cfg_clear = 1'b0; cfg_start = 1'b0;
        exp_coinc = 0;
        chk("t5_clr_busy", 32'(busy), 32'd0);
        chk("t5_clr_coinc", coinc_count, 32'd0);
        chk("t5_clr_singles", singles_count[31:0], 32'd0);
        tick(3);
        chk("t5_stay_idle", 32'(busy), 32'd0);
        cfg_mask = 4'b0011; do_start();
        ch_in = 4'b0001; tick(2); ch_in = '0; tick(3);
        chk("t5_pre_rst_singles", singles_count[31:0], 32'd1);
        ARESETN = 1'b0; #2;
        chk("t5_rst_singles", singles_count[31:0], 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_coinc", coinc_count, 32'd0);
        tick(1); ARESETN = 1'b1; tick(1);
        pulse(4'b0010); tick(4);
        chk("t5_post_rst_coinc", coinc_count, 32'd0);

        // 6: edges before start ignored; 4-bit build saturates at 15
        do_clear(); cfg_mask = 4'b0001; cfg_gate = 32'd0;
        for (int i = 0; i < 3; i++) pulse(4'b0001);
        tick(4);
        chk("t6_idle_singles", singles_count[31:0], 32'd0);
        chk("t6_idle_singles4", {28'd0, singles_count4[3:0]}, 32'd0);
        do_start();
        for (int i = 0; i < 20; i++) begin expect_coinc(); pulse(4'b0001); end
        tick(6);
        chk("t6_sat_coinc4", {28'd0, coinc_count4}, 32'd15);
        chk("t6_sat_singles4", {28'd0, singles_count4[3:0]}, 32'd15);
        chk("t6_wide_coinc", coinc_count, 32'd20);
        chk("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
